mm_reg_reader: RTL and testbench

//  Read-side responder for the memory-mapped register bank. The DFF_1/DFF_8

---
 rtl/mm_reg_pkg.sv | 6 +
 rtl/mm_rd_pipe.sv | 21 ++
 rtl/mm_reg_reader.sv | 64 ++++++
 tb/tb_mm_reg_reader.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mm_reg_pkg.sv
// mm_reg_pkg: shared state encoding and constants for the register read responder
package mm_reg_pkg;
    typedef enum logic [1:0] {INIT, IDLE, LOCKED} state_t;
    localparam int PKG_DATA_W = 8;
    localparam logic [PKG_DATA_W-1:0] ZERO = '0;
endpackage

// File: rtl/mm_rd_pipe.sv
// mm_rd_pipe: fixed-depth shift register carrying {valid, data} read responses
module mm_rd_pipe #(
    parameter int DEPTH = 2,
    parameter int W     = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] stage [DEPTH];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end
    assign q = stage[DEPTH-1];
endmodule

// File: rtl/mm_reg_reader.sv
// mm_reg_reader: Avalon-MM pipelined read responder with an atomic snapshot group at the low addresses
module mm_reg_reader
    import mm_reg_pkg::*;
#(
    parameter int NUM_REGS     = 8,
    parameter int ADDR_W       = 3,
    parameter int DATA_W       = 8,
    parameter int READ_LATENCY = 2,
    parameter int SNAP_BYTES   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REGS*DATA_W-1:0] reg_in,
    input  logic [ADDR_W-1:0]          avs_address,
    input  logic                       avs_read,
    output logic                       avs_waitrequest,
    output logic [DATA_W-1:0]          avs_readdata,
    output logic                       avs_readdatavalid,
    output logic                       snap_locked
);
    state_t state, next_state;
    logic accept, is_first, is_last;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] shadow [1:SNAP_BYTES-1];
    assign accept   = avs_read && !avs_waitrequest;
    assign is_first = avs_address == '0;
    assign is_last  = avs_address == ADDR_W'(SNAP_BYTES-1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= INIT;
        else     state <= next_state;
    end
    always_comb begin
        next_state = state == INIT                        ? IDLE
                   : accept && is_first                   ? LOCKED
                   : accept && is_last && state == LOCKED ? IDLE
                   : state;
    end
    always_comb begin
        avs_waitrequest = state == INIT;
        snap_locked     = state == LOCKED;
    end
    // byte 0 is served live because its snapshot is taken in the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 1; k < SNAP_BYTES; k++) shadow[k] <= '0;
        end else if (accept && is_first) begin
            for (int k = 1; k < SNAP_BYTES; k++) shadow[k] <= reg_in[k*DATA_W +: DATA_W];
        end
    end
    always_comb begin
        rd_data = DATA_W'(ZERO);
        for (int k = 1; k < SNAP_BYTES; k++)
            if (avs_address == ADDR_W'(k)) rd_data = shadow[k];
        for (int k = SNAP_BYTES; k < NUM_REGS; k++)
            if (avs_address == ADDR_W'(k)) rd_data = reg_in[k*DATA_W +: DATA_W];
        if (is_first) rd_data = reg_in[DATA_W-1:0];
    end
    mm_rd_pipe #(.DEPTH(READ_LATENCY), .W(1 + DATA_W)) u_pipe (
        .clk (clk),
        .rst (rst),
        .d   ({accept, accept ? rd_data : DATA_W'(ZERO)}),
        .q   ({avs_readdatavalid, avs_readdata})
    );
endmodule

// File: tb/tb_mm_reg_reader.sv
// tb_mm_reg_reader: scoreboard bench driving three latency builds of mm_reg_reader in lockstep
module tb_mm_reg_reader;
    localparam int N = 3;
    localparam int LATS [N] = '{1, 2, 4};
    typedef struct {
        logic [7:0] d;
        int         due;
    } exp_t;
    logic clk = 0, rst;
    logic [63:0] reg_in;
    logic [3:0] avs_address;
    logic avs_read;
    logic [N-1:0] wr, vld, lck;
    logic [7:0] dat [N];
    exp_t q [N][$];
    logic [7:0] shadow_m [4];
    logic locked_m;
    int cyc = 0, checks = 0, errors = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    for (genvar g = 0; g < N; g++) begin : duts
        mm_reg_reader #(.NUM_REGS(8), .ADDR_W(4), .DATA_W(8), .READ_LATENCY(LATS[g]), .SNAP_BYTES(4)) dut (
            .clk               (clk),
            .rst               (rst),
            .reg_in            (reg_in),
            .avs_address       (avs_address),
            .avs_read          (avs_read),
            .avs_waitrequest   (wr[g]),
            .avs_readdata      (dat[g]),
            .avs_readdatavalid (vld[g]),
            .snap_locked       (lck[g])
        );
    end
    function automatic logic [7:0] byte_of(input int k);
        return reg_in[k*8 +: 8];
    endfunction
    task automatic rd(input logic [3:0] a);
        logic [7:0] e;
        exp_t t;
        e = a == 0 ? byte_of(0) : a < 4 ? shadow_m[a[1:0]] : a < 8 ? byte_of(int'(a)) : 8'h00;
        avs_address = a;
        avs_read = 1;
        for (int g = 0; g < N; g++) begin
            t.d = e;
            t.due = cyc + LATS[g];
            q[g].push_back(t);
        end
        @(posedge clk); #1;
        if (a == 0) begin
            for (int k = 1; k < 4; k++) shadow_m[k] = byte_of(k);
            locked_m = 1;
        end else if (a == 3) locked_m = 0;
        avs_read = 0;
    endtask
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic set_bytes(input logic [7:0] b0, b1, b2, b3);
        reg_in[31:0] = {b3, b2, b1, b0};
    endtask
    task automatic check_wr(input logic [N-1:0] exp, input string name);
        checks++;
        if (wr !== exp) begin
            errors++;
            $display("FAIL %s waitrequest got=%b want=%b", name, wr, exp);
        end
    endtask
    always @(negedge clk) begin
        for (int g = 0; g < N; g++) begin
            if (rst) begin
                checks++;
                if (vld[g] !== 1'b0 || dat[g] !== 8'h00 || lck[g] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_outputs L%0d valid=%b data=%h locked=%b want 0/00/0", LATS[g], vld[g], dat[g], lck[g]);
                end
            end else begin
                if (vld[g]) begin
                    checks++;
                    if (q[g].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_valid L%0d cyc=%0d data=%h want no response", LATS[g], cyc, dat[g]);
                    end else begin
                        exp_t e;
                        e = q[g].pop_front();
                        if (e.due != cyc || e.d !== dat[g]) begin
                            errors++;
                            $display("FAIL response L%0d got cyc=%0d data=%h want cyc=%0d data=%h", LATS[g], cyc, dat[g], e.due, e.d);
                        end
                    end
                end else begin
                    if (q[g].size() > 0 && q[g][0].due <= cyc) begin
                        checks++;
                        errors++;
                        $display("FAIL missed_valid L%0d got no valid at cyc=%0d want data=%h at cyc=%0d", LATS[g], cyc, q[g][0].d, q[g][0].due);
                        void'(q[g].pop_front());
                    end
                    checks++;
                    if (dat[g] !== 8'h00) begin
                        errors++;
                        $display("FAIL idle_data L%0d got=%h want=00", LATS[g], dat[g]);
                    end
                end
                checks++;
                if (lck[g] !== locked_m) begin
                    errors++;
                    $display("FAIL snap_locked L%0d cyc=%0d got=%b want=%b", LATS[g], cyc, lck[g], locked_m);
                end
            end
        end
    end
    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end
    initial begin
        rst = 1;
        avs_read = 0;
        avs_address = 0;
        reg_in = '0;
        locked_m = 0;
        for (int k = 0; k < 4; k++) shadow_m[k] = 8'h00;
        idle(3);
        check_wr('1, "in_reset");
        rst = 0;
        check_wr('1, "init_cycle");
        idle(1);
        check_wr('0, "after_init");
        reg_in[47:40] = 8'hA5;
        rd(5);
        idle(5);
        set_bytes(8'h11, 8'h22, 8'h33, 8'h44);
        rd(0);
        set_bytes(8'h55, 8'h66, 8'h77, 8'h88);
        rd(1);
        rd(2);
        rd(3);
        idle(5);
        reg_in[63:32] = 32'hD4C3B2A1;
        for (int a = 4; a < 8; a++) rd(4'(a));
        idle(6);
        rd(0);
        rd(9);
        rd(15);
        idle(5);
        reg_in = {$urandom, $urandom};
        for (int a = 0; a < 8; a++) rd(4'(a));
        idle(6);
        for (int i = 0; i < 300; i++) begin
            if ($urandom % 4 == 0) reg_in = {$urandom, $urandom};
            rd(4'($urandom_range(0, 15)));
            if ($urandom % 3 == 0) idle($urandom_range(1, 3));
        end
        idle(6);
        set_bytes(8'hC1, 8'hC2, 8'hC3, 8'hC4);
        rd(0);
        rd(4);
        rd(6);
        rst = 1;
        for (int g = 0; g < N; g++) q[g].delete();
        locked_m = 0;
        for (int k = 0; k < 4; k++) shadow_m[k] = 8'h00;
        idle(2);
        rst = 0;
        check_wr('1, "init_after_reset");
        idle(1);
        check_wr('0, "idle_after_reset");
        rd(1);
        rd(2);
        idle(8);
        for (int g = 0; g < N; g++) begin
            checks++;
            if (q[g].size() != 0) begin
                errors++;
                $display("FAIL drain L%0d got %0d pending want 0", LATS[g], q[g].size());
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
